// File: rtl/axi4_usr_sram_ctrl_pkg.sv
// Shared definitions for the AXI4 user-side SRAM controller: bus-width macros,
// FSM state type and SRAM timing constants.
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef AXI4_WSTRB_WIDTH
`define AXI4_WSTRB_WIDTH (`AXI4_DATA_WIDTH/8)
`endif
`ifndef AXI4_DATA_BLOG
`define AXI4_DATA_BLOG 3
`endif

package axi4_usr_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_VALID = 3'd2,
        ST_WR       = 3'd3,
        ST_WR_RESP  = 3'd4
    } usr_sram_state_t;

    localparam int SRAM_RD_LAT = 1;
    localparam int BEAT_CNT_W  = 8;

endpackage

// File: rtl/axi4_usr_sram_ctrl_beat_cnt.sv
// 8-bit burst beat counter: load count and length, increment, last-beat compare.
module axi4_usr_beat_cnt
    import axi4_usr_sram_ctrl_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load_i,
    input  logic [BEAT_CNT_W-1:0] load_cnt_i,
    input  logic [BEAT_CNT_W-1:0] load_len_i,
    input  logic                  inc_i,
    output logic                  last_o
);

    logic [BEAT_CNT_W-1:0] cnt_q;
    logic [BEAT_CNT_W-1:0] len_q;

    assign last_o = (cnt_q == len_q);

    // Compare before incrementing so a 256-beat burst never wraps the count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_cnt_i;
            len_q <= load_len_i;
        end else if (inc_i && !last_o) begin
            cnt_q <= cnt_q + BEAT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi4_usr_sram_ctrl.sv
// Sequences the AXI4 slave FSM user port onto a single-port 1-cycle-latency SRAM.
// Optional beat counters enabled by defining AXI4_USR_SRAM_PERF_CNT_EN.
//   state       | meaning
//   ST_IDLE     | ready for address; read wins over write
//   ST_RD_WAIT  | SRAM read in flight, capture data next edge
//   ST_RD_VALID | hold register presented with rvalid until beat accepted
//   ST_WR       | accepting write beats, one SRAM write per beat
//   ST_WR_RESP  | bvalid until bready
module axi4_usr_sram_ctrl
    import axi4_usr_sram_ctrl_pkg::*;
#(
    parameter int  SRAM_DEPTH      = 4096,
    parameter int  USR_WADDR_WIDTH = 23,
    localparam int SRAM_AW         = $clog2(SRAM_DEPTH)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           arvalid_i,
    input  logic [7:0]                     arlen_i,
    input  logic                           awvalid_i,
    input  logic                           bready_i,
    input  logic                           usr_start_i,
    input  logic                           usr_rdwr_start_i,
    input  logic                           usr_wen_i,
    input  logic [7:0]                     usr_wlen_i,
    input  logic [USR_WADDR_WIDTH-1:0]     usr_addr_i,
    input  logic [`AXI4_WSTRB_WIDTH-1:0]   usr_bm_i,
    input  logic [`AXI4_DATA_WIDTH-1:0]    usr_dat_i,
    output logic [`AXI4_DATA_WIDTH-1:0]    usr_dat_o,
    output logic                           usr_awready_o,
    output logic                           usr_wready_o,
    output logic                           usr_bvalid_o,
    output logic                           usr_arready_o,
    output logic                           usr_rvalid_o,
    output logic                           sram_en_o,
    output logic                           sram_we_o,
    output logic [SRAM_AW-1:0]             sram_addr_o,
    output logic [`AXI4_WSTRB_WIDTH-1:0]   sram_bm_o,
    output logic [`AXI4_DATA_WIDTH-1:0]    sram_wdata_o,
    input  logic [`AXI4_DATA_WIDTH-1:0]    sram_rdata_i
`ifdef AXI4_USR_SRAM_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_rd_beats_o,
    output logic [31:0]                    perf_wr_beats_o
`endif
);

    usr_sram_state_t                state_q, state_d;
    logic                           active_q;
    logic [`AXI4_DATA_WIDTH-1:0]    hold_q;
    logic                           en, we;
    logic                           hold_cap;
    logic                           rd_acc, wr_acc;
    logic                           cnt_load, cnt_inc, cnt_last;
    logic [BEAT_CNT_W-1:0]          cnt_load_val, len_load_val;
    logic                           unused_addr_hi;

    assign unused_addr_hi = ^usr_addr_i[USR_WADDR_WIDTH-1:SRAM_AW];

    axi4_usr_beat_cnt u_beat_cnt (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load_i     (cnt_load),
        .load_cnt_i (cnt_load_val),
        .load_len_i (len_load_val),
        .inc_i      (cnt_inc),
        .last_o     (cnt_last)
    );

    // active_q keeps every output low until the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            if (hold_cap) begin
                hold_q <= sram_rdata_i;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        usr_arready_o = 1'b0;
        usr_awready_o = 1'b0;
        usr_wready_o  = 1'b0;
        usr_bvalid_o  = 1'b0;
        usr_rvalid_o  = 1'b0;
        en            = 1'b0;
        we            = 1'b0;
        hold_cap      = 1'b0;
        rd_acc        = 1'b0;
        wr_acc        = 1'b0;
        cnt_load      = 1'b0;
        cnt_inc       = 1'b0;
        cnt_load_val  = '0;
        len_load_val  = '0;
        if (active_q) begin
            case (state_q)
                ST_IDLE: begin
                    usr_arready_o = 1'b1;
                    usr_awready_o = awvalid_i & ~arvalid_i;
                    usr_wready_o  = awvalid_i & ~arvalid_i;
                    if (usr_start_i && arvalid_i) begin
                        en           = 1'b1;
                        cnt_load     = 1'b1;
                        len_load_val = arlen_i;
                        state_d      = ST_RD_WAIT;
                    end else if (usr_start_i) begin
                        cnt_load     = 1'b1;
                        len_load_val = usr_wlen_i;
                        state_d      = ST_WR;
                        if (usr_rdwr_start_i && usr_wen_i) begin
                            en     = 1'b1;
                            we     = 1'b1;
                            wr_acc = 1'b1;
                            if (usr_wlen_i == '0) begin
                                state_d = ST_WR_RESP;
                            end else begin
                                cnt_load_val = BEAT_CNT_W'(1);
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    hold_cap = 1'b1;
                    state_d  = ST_RD_VALID;
                end
                ST_RD_VALID: begin
                    usr_rvalid_o = 1'b1;
                    if (usr_rdwr_start_i) begin
                        rd_acc = 1'b1;
                        if (cnt_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_inc = 1'b1;
                            en      = 1'b1;
                            state_d = ST_RD_WAIT;
                        end
                    end
                end
                ST_WR: begin
                    usr_wready_o = 1'b1;
                    if (usr_rdwr_start_i && usr_wen_i) begin
                        en     = 1'b1;
                        we     = 1'b1;
                        wr_acc = 1'b1;
                        if (cnt_last) begin
                            state_d = ST_WR_RESP;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    usr_bvalid_o = 1'b1;
                    if (bready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign usr_dat_o    = hold_q;
    assign sram_en_o    = en;
    assign sram_we_o    = we;
    assign sram_addr_o  = en ? usr_addr_i[SRAM_AW-1:0] : '0;
    assign sram_bm_o    = (en && we) ? usr_bm_i : '0;
    assign sram_wdata_o = (en && we) ? usr_dat_i : '0;

`ifdef AXI4_USR_SRAM_PERF_CNT_EN
    logic [31:0] perf_rd_q, perf_wr_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perf_rd_q <= '0;
            perf_wr_q <= '0;
        end else begin
            if (rd_acc) perf_rd_q <= perf_rd_q + 32'd1;
            if (wr_acc) perf_wr_q <= perf_wr_q + 32'd1;
        end
    end

    assign perf_rd_beats_o = perf_rd_q;
    assign perf_wr_beats_o = perf_wr_q;
`else
    logic unused_perf;
    assign unused_perf = rd_acc ^ wr_acc;
`endif

endmodule

// File: tb/tb_axi4_usr_sram_ctrl.sv
// Randomized bench for axi4_usr_sram_ctrl: the driver plays the AXI4 slave FSM and
// predicts every output per cycle from transaction-level rules and a reference memory.
module tb_axi4_usr_sram_ctrl;
    localparam int DW = 64, BW = 8, AW = 12, UAW = 23, DEPTH = 4096;

    logic            aclk, aresetn;
    logic            arvalid, awvalid, bready, usr_start, usr_rdwr_start, usr_wen;
    logic [7:0]      arlen, usr_wlen;
    logic [UAW-1:0]  usr_addr;
    logic [BW-1:0]   usr_bm;
    logic [DW-1:0]   usr_dat, usr_dat_o;
    logic            awready, wready, bvalid, arready, rvalid, sram_en, sram_we;
    logic [AW-1:0]   sram_addr;
    logic [BW-1:0]   sram_bm;
    logic [DW-1:0]   sram_wdata, sram_rdata;
    logic [31:0]     perf_rd, perf_wr;

    // expectations for the current cycle
    logic            e_arready, e_awready, e_wready, e_bvalid, e_rvalid, e_en, e_we, in_rst;
    logic [AW-1:0]   e_addr;
    logic [BW-1:0]   e_bm;
    logic [DW-1:0]   e_wdata, e_dat, lit_val;
    logic [31:0]     e_prd, e_pwr;
    int              lit_kind;
    logic [AW-1:0]   lit_addr;
    logic            chk_on, mem_clr;
    int              m_rd, m_wr, n_chk, n_pass;
    logic [DW-1:0]   ref_mem [DEPTH];
    logic [DW-1:0]   sram_mem [DEPTH];

    axi4_usr_sram_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .arvalid_i(arvalid), .arlen_i(arlen),
        .awvalid_i(awvalid), .bready_i(bready), .usr_start_i(usr_start),
        .usr_rdwr_start_i(usr_rdwr_start), .usr_wen_i(usr_wen), .usr_wlen_i(usr_wlen),
        .usr_addr_i(usr_addr), .usr_bm_i(usr_bm), .usr_dat_i(usr_dat), .usr_dat_o(usr_dat_o),
        .usr_awready_o(awready), .usr_wready_o(wready), .usr_bvalid_o(bvalid),
        .usr_arready_o(arready), .usr_rvalid_o(rvalid), .sram_en_o(sram_en),
        .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_bm_o(sram_bm),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
`ifdef AXI4_USR_SRAM_PERF_CNT_EN
        , .perf_rd_beats_o(perf_rd), .perf_wr_beats_o(perf_wr)
`endif
    );

`ifndef AXI4_USR_SRAM_PERF_CNT_EN
    assign perf_rd = '0;
    assign perf_wr = '0;
`endif

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // behavioural SRAM macro, 1-cycle read latency
    always @(posedge aclk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= '0;
        end else if (sram_en && sram_we) begin
            for (int b = 0; b < BW; b++)
                if (sram_bm[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
        if (sram_en && !sram_we) sram_rdata <= sram_mem[sram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge aclk) begin
        if (chk_on) begin
            chk("arready", 64'(arready), 64'(e_arready));
            chk("awready", 64'(awready), 64'(e_awready));
            chk("wready",  64'(wready),  64'(e_wready));
            chk("bvalid",  64'(bvalid),  64'(e_bvalid));
            chk("rvalid",  64'(rvalid),  64'(e_rvalid));
            chk("sram_en", 64'(sram_en), 64'(e_en));
            chk("sram_we", 64'(sram_we), 64'(e_we));
            if (e_en || in_rst) chk("sram_addr", 64'(sram_addr), 64'(e_addr));
            if ((e_en && e_we) || in_rst) begin
                chk("sram_bm", 64'(sram_bm), 64'(e_bm));
                chk("sram_wdata", sram_wdata, e_wdata);
            end
            if (e_rvalid || in_rst) chk("usr_dat", usr_dat_o, e_dat);
`ifdef AXI4_USR_SRAM_PERF_CNT_EN
            chk("perf_rd", 64'(perf_rd), 64'(e_prd));
            chk("perf_wr", 64'(perf_wr), 64'(e_pwr));
`endif
            if (lit_kind == 1) begin
                chk("lit_sram", sram_mem[lit_addr], lit_val);
                chk("lit_ref", ref_mem[lit_addr], lit_val);
            end
            if (lit_kind == 2) chk("lit_rdata", usr_dat_o, lit_val);
        end
    end

    task automatic clr();
        arvalid = 0; arlen = 0; awvalid = 0; bready = 0; usr_start = 0;
        usr_rdwr_start = 0; usr_wen = 0; usr_wlen = 0;
        usr_addr = UAW'($urandom); usr_bm = BW'($urandom); usr_dat = {$urandom, $urandom};
        e_arready = 0; e_awready = 0; e_wready = 0; e_bvalid = 0; e_rvalid = 0;
        e_en = 0; e_we = 0; e_addr = 0; e_bm = 0; e_wdata = 0; e_dat = 0;
        in_rst = 0; lit_kind = 0;
    endtask

    task automatic tick();
        @(posedge aclk); #1;
        clr();
        e_prd = 32'(m_rd);
        e_pwr = 32'(m_wr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin tick(); e_arready = 1; end
    endtask

    task automatic wbeat(input logic [UAW-1:0] a, input int beat, input int mask_beat,
                         input logic [7:0] mask_val, input logic [63:0] mask_dat, input logic rnd_bm);
        logic [UAW-1:0] ba;
        ba = a + UAW'(beat);
        usr_rdwr_start = 1; usr_wen = 1; usr_addr = ba;
        if (beat == mask_beat) begin usr_bm = mask_val; usr_dat = mask_dat; end
        else usr_bm = rnd_bm ? BW'($urandom) : 8'hFF;
        e_en = 1; e_we = 1; e_addr = ba[AW-1:0]; e_bm = usr_bm; e_wdata = usr_dat;
        for (int b = 0; b < BW; b++)
            if (usr_bm[b]) ref_mem[ba[AW-1:0]][b*8 +: 8] = usr_dat[b*8 +: 8];
        m_wr++;
    endtask

    task automatic do_write(input logic [UAW-1:0] a, input int len, input logic first_now,
                            input int mask_beat, input logic [7:0] mask_val,
                            input logic [63:0] mask_dat, input logic rnd_bm, input int gap_pct);
        int beat = 0;
        tick();
        e_arready = 1; awvalid = 1; usr_start = 1; usr_wlen = 8'(len); usr_addr = a;
        e_awready = 1; e_wready = 1;
        if (first_now) begin wbeat(a, 0, mask_beat, mask_val, mask_dat, rnd_bm); beat = 1; end
        while (beat <= len) begin
            tick(); e_wready = 1;
            if (int'($urandom_range(0, 99)) < gap_pct) usr_wen = 1'($urandom);
            else begin wbeat(a, beat, mask_beat, mask_val, mask_dat, rnd_bm); beat++; end
        end
        for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin tick(); e_bvalid = 1; end
        tick(); e_bvalid = 1; bready = 1;
    endtask

    task automatic do_read(input logic [UAW-1:0] a, input int len, input int stall_beat,
                           input int stall_n, input logic aw_too, input logic lit_en,
                           input logic [63:0] lit_d);
        logic [UAW-1:0] ba;
        int ns;
        tick();
        e_arready = 1; arvalid = 1; arlen = 8'(len); usr_start = 1; usr_addr = a; awvalid = aw_too;
        e_en = 1; e_addr = a[AW-1:0];
        for (int k = 0; k <= len; k++) begin
            ba = a + UAW'(k);
            tick(); awvalid = aw_too;
            ns = (k == stall_beat) ? stall_n : int'($urandom_range(0, 2));
            for (int s = 0; s <= ns; s++) begin
                tick(); awvalid = aw_too; e_rvalid = 1; e_dat = ref_mem[ba[AW-1:0]];
                if (lit_en && k == 0) begin lit_kind = 2; lit_val = lit_d; end
            end
            usr_rdwr_start = 1; m_rd++;
            if (k < len) begin
                ba = a + UAW'(k + 1);
                usr_addr = ba; e_en = 1; e_addr = ba[AW-1:0];
            end
        end
    endtask

    task automatic lit_mem(input logic [AW-1:0] addr, input logic [63:0] v);
        tick(); e_arready = 1; lit_kind = 1; lit_addr = addr; lit_val = v;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_pass = 0; m_rd = 0; m_wr = 0; chk_on = 0; mem_clr = 1; aresetn = 0;
        e_prd = 0; e_pwr = 0; lit_val = 0; lit_addr = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        clr();
        repeat (2) @(posedge aclk);
        #1 mem_clr = 0;
        chk_on = 1; in_rst = 1;
        tick(); in_rst = 1;
        tick(); aresetn = 1;
        idle(2);

        // single write then single read of a known word
        do_write(23'h10, 0, 1'b1, 0, 8'hFF, 64'h0000_0000_DEAD_BEEF, 1'b0, 0);
        lit_mem(12'h010, 64'h0000_0000_DEAD_BEEF);
        do_read(23'h10, 0, -1, 0, 1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF);
        idle(1);

        // INCR read with a long stall on beat 1
        do_write(23'h40, 3, 1'b0, -1, 8'h00, 64'h0, 1'b0, 0);
        do_read(23'h40, 3, 1, 5, 1'b0, 1'b0, 64'h0);

        // 8-beat write with gaps, beat 3 masked to the low four bytes
        do_write(23'h80, 7, 1'b1, 3, 8'h0F, 64'h1111_2222_3333_4444, 1'b0, 40);
        lit_mem(12'h083, 64'h0000_0000_3333_4444);

        // arvalid and awvalid together: read wins, write follows
        tick(); e_arready = 1; arvalid = 1; awvalid = 1;
        do_read(23'h80, 7, -1, 0, 1'b1, 1'b0, 64'h0);
        do_write(23'h100, 2, 1'b1, -1, 8'h00, 64'h0, 1'b1, 20);

        // address aliasing above the SRAM width
        do_write(23'h1200, 0, 1'b0, 0, 8'hFF, 64'hCAFE_F00D_0123_4567, 1'b0, 0);
        lit_mem(12'h200, 64'hCAFE_F00D_0123_4567);

        // 256-beat bursts
        do_write(23'hE00, 255, 1'b1, -1, 8'h00, 64'h0, 1'b0, 10);
        do_read(23'hE00, 255, -1, 0, 1'b0, 1'b0, 64'h0);

        for (int t = 0; t < 40; t++) begin
            logic [UAW-1:0] ra;
            int rl;
            ra = UAW'($urandom);
            rl = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(ra, rl, 1'($urandom), -1, 8'h00, 64'h0, 1'b1, 30);
            else do_read(ra, rl, -1, 0, 1'($urandom), 1'b0, 64'h0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        // reset in the middle of a 16-beat write
        tick(); e_arready = 1; awvalid = 1; usr_start = 1; usr_wlen = 8'd15; usr_addr = 23'h300;
        e_awready = 1; e_wready = 1;
        wbeat(23'h300, 0, -1, 8'h00, 64'h0, 1'b0);
        for (int k = 1; k < 5; k++) begin
            tick(); e_wready = 1; wbeat(23'h300, k, -1, 8'h00, 64'h0, 1'b0);
        end
        tick(); aresetn = 0; in_rst = 1; m_rd = 0; m_wr = 0; e_prd = 0; e_pwr = 0;
        tick(); in_rst = 1;
        tick(); aresetn = 1;
        idle(2);
        do_read(23'h300, 7, -1, 0, 1'b0, 1'b0, 64'h0);
        idle(2);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
